// File: rtl/pipelined_wallace_mult_if.sv
// pipelined_wallace_mult_if: operand/product valid-ready bundle
// for the pipelined Wallace-tree multiplier.
interface pipelined_wallace_mult_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/pipelined_wallace_mult.sv
// pipelined_wallace_mult: Wallace CSA tree + CPA over PIPE_STAGES regs.
// Define WALLACE_MULT_SIGNED_EN to honour signed_mode (Baugh-Wooley).
module pipelined_wallace_mult #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_wallace_mult_if.slave io
);

  localparam int PW = 2 * WIDTH;
`ifdef WALLACE_MULT_SIGNED_EN
  localparam int NR = WIDTH + 1;
`else
  localparam int NR = WIDTH;
`endif

  function automatic int nlayers();
    int n = NR;
    int l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  // T steps: CSA layers followed by the final carry-propagate add
  localparam int T  = nlayers() + 1;
  localparam int SQ = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int rows_at(int i);
    int n = NR;
    for (int k = 0; k < i; k++)
      n = n - n / 3;
    return n;
  endfunction

  function automatic rows_t step(rows_t r, int i);
    rows_t o = '0;
    int n = rows_at(i);
    int g3 = n / 3;
    if (i == T - 1) begin
      o[0] = r[0] + r[1];
    end else begin
      for (int g = 0; g < NR / 3; g++)
        if (g < g3) begin
          o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
          o[2*g+1] = ((r[3*g] & r[3*g+1]) |
                      (r[3*g+2] & (r[3*g] ^ r[3*g+1]))) << 1;
        end
      for (int k = 0; k < 2; k++)
        if (k < n - 3 * g3)
          o[2*g3+k] = r[3*g3+k];
    end
    return o;
  endfunction

  // stage s (1-based) owns steps spread evenly, CPA always in the last
  function automatic rows_t run(rows_t r, int s);
    rows_t o = r;
    for (int i = 0; i < T; i++)
      if (1 + ((i + 1) * PIPE_STAGES - 1) / T == s)
        o = step(o, i);
    return o;
  endfunction

  logic                   adv;
  logic                   sm_in;
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] sm_q;
  logic [PW-1:0]          prod_q;
  rows_t                  pp;
  rows_t                  st_q [SQ];

  assign io.in_ready  = !io.out_valid || io.out_ready;
  assign io.out_valid = vld_q[PIPE_STAGES-1];
  assign io.product   = prod_q;
  assign adv          = io.in_ready;

`ifdef WALLACE_MULT_SIGNED_EN
  assign sm_in = io.signed_mode;

  always_comb begin
    pp = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        pp[j][i+j] = (io.a[i] & io.b[j]) ^
          (sm_in & ((i == WIDTH - 1) != (j == WIDTH - 1)));
    pp[WIDTH][WIDTH] = sm_in;
    pp[WIDTH][PW-1]  = sm_in;
  end
`else
  logic unused_sm;
  assign unused_sm = io.signed_mode;
  assign sm_in     = 1'b0;

  always_comb begin
    pp = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        pp[j][i+j] = io.a[i] & io.b[j];
  end
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      sm_q  <= '0;
    end else if (adv) begin
      vld_q <= (vld_q << 1) | PIPE_STAGES'(io.in_valid);
      sm_q  <= (sm_q << 1) | PIPE_STAGES'(sm_in);
    end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_st
    rows_t src;
    if (s == 0) begin : g_first
      assign src = pp;
    end else begin : g_mid
      assign src = st_q[s-1];
    end
    if (s < PIPE_STAGES - 1) begin : g_reg
      always_ff @(posedge clk)
        if (adv) st_q[s] <= run(src, s + 1);
    end else begin : g_out
      rows_t res;
      logic  unused_res;
      assign res        = run(src, s + 1);
      assign unused_res = ^res[NR-1:1];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   prod_q <= '0;
        else if (adv) prod_q <= res[0];
    end
  end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// tb_pipelined_wallace_mult: random + directed checks against
// a plain-arithmetic queue model of the multiplier.
module tb_pipelined_wallace_mult;
  localparam int W = 8;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nbad = 0;

  logic [2*W-1:0] exp_q[$];

  pipelined_wallace_mult_if #(.WIDTH(W)) mi ();

  pipelined_wallace_mult #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (mi)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    longint p;
    p = longint'(x) * longint'(y);
`ifdef WALLACE_MULT_SIGNED_EN
    if (sm) p = longint'($signed(x)) * longint'($signed(y));
`else
    if (sm) p = longint'(x) * longint'(y);
`endif
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // model scoreboard: accepts push, consumed outputs pop
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", 32'(mi.out_valid), 32'd0);
      chk("rst_product", 32'(mi.product), 32'd0);
      chk("rst_in_ready", 32'(mi.in_ready), 32'd1);
    end else begin
      chk("in_ready", 32'(mi.in_ready),
          32'(!mi.out_valid || mi.out_ready));
      if (mi.out_valid) begin
        if (exp_q.size() == 0)
          chk("spurious_out_valid", 32'(mi.out_valid), 32'd0);
        else begin
          chk("product", 32'(mi.product), 32'(exp_q[0]));
          if (mi.out_ready) void'(exp_q.pop_front());
        end
      end
      if (mi.in_valid && mi.in_ready)
        exp_q.push_back(model(mi.a, mi.b, mi.signed_mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic sm);
    bit acc = 1'b0;
    int g = 0;
    mi.a = x;
    mi.b = y;
    mi.signed_mode = sm;
    mi.in_valid = 1'b1;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = mi.in_ready;
      g++;
      tick();
    end
    if (!acc) begin
      nvec++;
      nbad++;
      $display("FAIL send_timeout: in_ready got 0, want 1");
    end
  endtask

  task automatic expect_out(input string nm, input logic v,
                            input logic [2*W-1:0] p);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(mi.out_valid), 32'(v));
    if (v) chk({nm, "_product"}, 32'(mi.product), 32'(p));
    tick();
  endtask

  task automatic drain(input string nm);
    int g = 0;
    mi.in_valid = 1'b0;
    mi.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk(nm, exp_q.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'hFF;
      4: return 8'h01;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit acc;
    int sent;
    mi.in_valid = 1'b0;
    mi.a = '0;
    mi.b = '0;
    mi.signed_mode = 1'b0;
    mi.out_ready = 1'b1;

    chk("pin_uFFxFF", 32'(model(8'hFF, 8'hFF, 1'b0)), 32'h0000FE01);
    chk("pin_uFFx01", 32'(model(8'hFF, 8'h01, 1'b0)), 32'h000000FF);
    chk("pin_s80x80", 32'(model(8'h80, 8'h80, 1'b1)), 32'h00004000);
`ifdef WALLACE_MULT_SIGNED_EN
    chk("pin_sFFx01", 32'(model(8'hFF, 8'h01, 1'b1)), 32'h0000FFFF);
    chk("pin_s7Fx80", 32'(model(8'h7F, 8'h80, 1'b1)), 32'h0000C080);
`else
    chk("pin_sFFx01", 32'(model(8'hFF, 8'h01, 1'b1)), 32'h000000FF);
`endif

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(8'hFF, 8'hFF, 1'b0);
    mi.in_valid = 1'b0;
    expect_out("lat_c1", 1'b0, '0);
    expect_out("lat_c2", 1'b0, '0);
    expect_out("lat_c3", 1'b1, 16'hFE01);
    drain("drain_lat");

    send(8'h80, 8'h80, 1'b1);
    send(8'hFF, 8'h01, 1'b1);
    send(8'hFF, 8'h01, 1'b0);
    mi.in_valid = 1'b0;
    expect_out("s80x80", 1'b1, 16'h4000);
`ifdef WALLACE_MULT_SIGNED_EN
    expect_out("sFFx01", 1'b1, 16'hFFFF);
`else
    expect_out("sFFx01", 1'b1, 16'h00FF);
`endif
    expect_out("uFFx01", 1'b1, 16'h00FF);
    drain("drain_modes");

    send(8'h00, 8'h37, 1'b0);
    send(8'h01, 8'h01, 1'b0);
    send(8'h10, 8'h10, 1'b0);
    mi.in_valid = 1'b0;
    expect_out("b2b0", 1'b1, 16'h0000);
    expect_out("b2b1", 1'b1, 16'h0001);
    expect_out("b2b2", 1'b1, 16'h0100);
    drain("drain_b2b");

    mi.out_ready = 1'b0;
    send(8'h03, 8'h05, 1'b0);
    send(8'h07, 8'h09, 1'b0);
    send(8'h0B, 8'h0D, 1'b0);
    mi.a = 8'h11;
    mi.b = 8'h13;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(mi.in_ready), 32'd0);
      chk("stall_out_valid", 32'(mi.out_valid), 32'd1);
      chk("stall_hold", 32'(mi.product), 32'h000F);
      tick();
    end
    mi.out_ready = 1'b1;
    send(8'h11, 8'h13, 1'b0);
    send(8'h17, 8'h1D, 1'b0);
    drain("drain_stall");

    mi.out_ready = 1'b0;
    send(8'h21, 8'h22, 1'b0);
    send(8'h23, 8'h24, 1'b0);
    send(8'h25, 8'h26, 1'b0);
    mi.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(mi.out_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_imm_valid", 32'(mi.out_valid), 32'd0);
    chk("rst_imm_product", 32'(mi.product), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mi.out_ready = 1'b1;
    for (int k = 0; k < 5; k++)
      expect_out("post_rst", 1'b0, '0);

    sent = 0;
    acc = 1'b1;
    mi.in_valid = 1'b0;
    while (sent < 10000) begin
      if (!mi.in_valid || acc) begin
        mi.a = pick();
        mi.b = pick();
        mi.signed_mode = 1'($urandom_range(0, 1));
        mi.in_valid = ($urandom_range(0, 3) != 0);
      end
      mi.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = mi.in_valid && mi.in_ready;
      if (acc) sent++;
      tick();
    end
    drain("drain_rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/pipelined_wallace_mult.md
PIPELINED_WALLACE_MULT -- requirements
Module: pipelined_wallace_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 4 to 32.
REQ-002 SHALL have parameter PIPE_STAGES, default 3: register stages from operand accept to product out; legal range 1 to 4.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1: a, b and signed_mode are valid this cycle.
REQ-006 SHALL have port in_ready  output  1: the block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH: multiplicand.
REQ-008 SHALL have port b  input  WIDTH: multiplier.
REQ-009 SHALL have port signed_mode  input  1: operands are two's complement when 1 and unsigned when 0; sampled with a and b.
REQ-010 SHALL have port out_valid  output  1: product holds a valid result.
REQ-011 SHALL have port out_ready  input  1: the consumer takes product this cycle.
REQ-012 SHALL have port product  output  2*WIDTH: full-width, non-truncated product.

Function
REQ-013 SHALL generate the WIDTH*WIDTH partial-product matrix and reduce it with Wallace-tree full/half-adder layers to two rows, then sum the two rows with a carry-propagate adder.
REQ-014 SHALL distribute the reduction layers and the final adder across PIPE_STAGES register stages; each stage carries one valid bit and the signed_mode flag.
REQ-015 SHALL accept operands when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL drive in_ready = !out_valid || out_ready. This is a global stall: every stage advances only when in_ready is 1.
REQ-017 SHALL raise out_valid exactly PIPE_STAGES cycles after acceptance when out_ready is held 1, giving a throughput of one result per cycle.
REQ-018 SHALL hold product and out_valid stable while out_valid is 1 and out_ready is 0.
REQ-019 SHALL propagate bubbles: a cycle with in_valid=0 and in_ready=1 inserts an invalid slot, and out_valid is 0 when that slot reaches the output.
REQ-020 SHALL produce product = a*b modulo 2^(2*WIDTH) when the operation is unsigned, and the exact two's-complement product when it is signed. The signed product includes the (-2^(WIDTH-1))^2 case.
REQ-021 SHALL keep each operation's signed_mode bound to its own operands. Mixed modes in flight never cross-contaminate.
REQ-022 SHALL always produce results in acceptance order.

Reset
REQ-023 SHALL, while rst_n=0, clear every stage valid bit and force out_valid=0 and product=0.
REQ-024 SHALL drive in_ready=1 during reset and on the first cycle after release.
REQ-025 SHALL discard all in-flight operations when reset asserts mid-operation; no stale result appears after release.
REQ-026 Data registers other than product need not be reset.

Configuration
REQ-027 SHALL support the macro WALLACE_MULT_SIGNED_EN.
- Defined: signed_mode is honoured, and the partial-product matrix uses Baugh-Wooley sign correction.
- Undefined: signed_mode is ignored, all operations are unsigned, and no sign-correction logic is instantiated.

Verification
REQ-028 SHALL pass with WIDTH=8 and PIPE_STAGES=3 on the following scenarios:
- Unsigned a=0xFF, b=0xFF, out_ready=1 -> product=0xFE01 with out_valid=1 exactly 3 cycles after accept.
- Signed a=0x80, b=0x80 -> 0x4000; signed a=0xFF, b=0x01 -> 0xFFFF; the same pair unsigned -> 0x00FF (macro defined).
- Back-to-back stream of 0x00*0x37, 0x01*0x01, 0x10*0x10 with out_ready=1 -> 0x0000, 0x0001, 0x0100 on consecutive cycles.
- Stream with out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, product held; after release, results appear in order with none lost or duplicated.
- rst_n pulsed low with 3 operations in flight -> out_valid=0 immediately; no result appears in the 5 cycles after release.
- Random 10k operands with mixed signed_mode and random out_ready -> every result matches the reference model.
